// File: rtl/grf_scoreboard_pkg.sv
// Shared pipeline constants and types for the D-stage register file.
package grf_scoreboard_pkg;

    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned AW_DEF   = 5;
    localparam int unsigned DW_DEF   = 32;
    localparam int unsigned CW_DEF   = 2;

    // Architectural register numbers with fixed meaning.
    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_RA   = 31;

    // One pending-write counter: producers in flight in E, M and W.
    typedef logic [CW_DEF-1:0] pcnt_t;

endpackage

// File: rtl/grf_pending_cnt.sv
// Saturating up/down pending-write counter for one architectural register.
// err flags an update that had to saturate high or clamp at zero.
module grf_pending_cnt #(
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic [1:0]    dec,
    output logic [CW-1:0] count,
    output logic          err
);

    localparam int unsigned MAXV = (1 << CW) - 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW+1:0] up;
    logic [CW+1:0] dec_ext;
    logic [CW+1:0] diff;

    // Net update with saturation at both ends.
    always_comb begin
        up      = {2'b00, cnt_q} + {{(CW+1){1'b0}}, inc};
        dec_ext = {{CW{1'b0}}, dec};
        diff    = up - dec_ext;
        cnt_d   = cnt_q;
        err     = 1'b0;
        if (up < dec_ext) begin
            cnt_d = '0;
            err   = 1'b1;
        end else if (diff > (CW+2)'(MAXV)) begin
            cnt_d = '1;
            err   = 1'b1;
        end else begin
            cnt_d = diff[CW-1:0];
        end
    end

    // Counter register, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/grf_scoreboard.sv
// D-stage general register file with W->D bypass and a per-register
// pending-write scoreboard that generates the D-stage stall.
module grf_scoreboard
    import grf_scoreboard_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned CW   = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic          use1,
    input  logic          use2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          stall,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_wa,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          kill_valid,
    input  logic [AW-1:0] kill_wa,
    output logic          sb_err
);

    localparam logic [AW-1:0] RZ = AW'(REG_ZERO);

    logic [DW-1:0]   regs_q [NREG];
    logic [CW-1:0]   cnt    [NREG];
    logic [NREG-1:0] err_vec;
    logic            sb_err_q;

    logic hit1;
    logic hit2;
    logic pend1;
    logic pend2;
    logic acc;

    assign cnt[0]     = '0;
    assign err_vec[0] = 1'b0;

    // Register storage; register 0 is never written and stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (wa != RZ)) begin
            regs_q[wa] <= wd;
        end
    end

    // Read ports with same-cycle bypass of the W-stage write.
    always_comb begin
        hit1 = we && (wa == ra1) && (ra1 != RZ);
        hit2 = we && (wa == ra2) && (ra2 != RZ);
        rd1  = '0;
        rd2  = '0;
        if (ra1 == RZ) begin
            rd1 = '0;
        end else if (hit1) begin
            rd1 = wd;
        end else begin
            rd1 = regs_q[ra1];
        end
        if (ra2 == RZ) begin
            rd2 = '0;
        end else if (hit2) begin
            rd2 = wd;
        end else begin
            rd2 = regs_q[ra2];
        end
    end

    // A source is still pending if more producers are in flight than the
    // one retiring this cycle. Comparing cnt > hit (instead of cnt - hit)
    // keeps an unscoreboarded write to a zero count from looking pending.
    always_comb begin
        pend1 = cnt[ra1] > CW'(hit1);
        pend2 = cnt[ra2] > CW'(hit2);
        stall = !reset && ((use1 && pend1) || (use2 && pend2));
        acc   = iss_valid && !stall && (iss_wa != RZ);
    end

    // One pending counter per writable register.
    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        logic       inc;
        logic       wdec;
        logic       kdec;
        logic [1:0] dec;

        assign inc  = acc && (iss_wa == AW'(r));
        // A write with nothing pending is legal and must not underflow.
        assign wdec = we && (wa == AW'(r)) && (cnt[r] != '0);
        assign kdec = kill_valid && (kill_wa == AW'(r));
        assign dec  = {1'b0, wdec} + {1'b0, kdec};

        grf_pending_cnt #(
            .CW (CW)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (inc),
            .dec   (dec),
            .count (cnt[r]),
            .err   (err_vec[r])
        );
    end

    // Sticky overflow/underflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_err_q <= 1'b0;
        end else if (|err_vec) begin
            sb_err_q <= 1'b1;
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed self-checking bench for grf_scoreboard.
module tb_grf_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ra1, ra2;
    logic        use1, use2;
    logic [31:0] rd1, rd2;
    logic        stall;
    logic        iss_valid;
    logic [4:0]  iss_wa;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        kill_valid;
    logic [4:0]  kill_wa;
    logic        sb_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    grf_scoreboard #(
        .NREG (32),
        .AW   (5),
        .DW   (32),
        .CW   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ra1        (ra1),
        .ra2        (ra2),
        .use1       (use1),
        .use2       (use2),
        .rd1        (rd1),
        .rd2        (rd2),
        .stall      (stall),
        .iss_valid  (iss_valid),
        .iss_wa     (iss_wa),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .kill_valid (kill_valid),
        .kill_wa    (kill_wa),
        .sb_err     (sb_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        iss_valid  = 1'b0;
        iss_wa     = '0;
        we         = 1'b0;
        wa         = '0;
        wd         = '0;
        kill_valid = 1'b0;
        kill_wa    = '0;
        use1       = 1'b0;
        use2       = 1'b0;
        ra1        = '0;
        ra2        = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle();
        ra1 = 5'd5; use1 = 1'b1; use2 = 1'b1;
        tick();
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_hold_stall: got %b want 0", stall); end
        n_checks++;
        if (rd1 !== 32'h0) begin n_fail++; $display("FAIL reset_hold_rd1: got %h want 0", rd1); end
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (rd1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1: got %h want 0", rd1); end
        n_checks++;
        if (rd2 !== 32'h0) begin n_fail++; $display("FAIL reset_rd2: got %h want 0", rd2); end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_checks++;
        if (sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_sb_err: got %b want 0", sb_err); end
    endtask

    task automatic test_bypass_stall;
        idle();
        iss_valid = 1'b1; iss_wa = 5'd8;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL issue8_stall: got %b want 0", stall); end
        tick();
        // Stalled issue to $10 must be dropped.
        iss_valid = 1'b1; iss_wa = 5'd10; ra1 = 5'd8; use1 = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL dep8_stall: got %b want 1", stall); end
        tick();
        iss_valid = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL dep8_hold: got %b want 1", stall); end
        tick();
        we = 1'b1; wa = 5'd8; wd = 32'h1234ABCD;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL wb8_stall: got %b want 0", stall); end
        n_checks++;
        if (rd1 !== 32'h1234ABCD) begin n_fail++; $display("FAIL wb8_bypass: got %h want 1234abcd", rd1); end
        tick();
        idle();
        ra1 = 5'd8; use1 = 1'b1; ra2 = 5'd10; use2 = 1'b1;
        #1;
        n_checks++;
        if (rd1 !== 32'h1234ABCD) begin n_fail++; $display("FAIL reg8_read: got %h want 1234abcd", rd1); end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL cnt8_cnt10_clear: got %b want 0", stall); end
        tick();
    endtask

    task automatic test_saturate;
        logic exp_st [3];
        exp_st = '{1'b1, 1'b1, 1'b0};
        idle();
        iss_valid = 1'b1; iss_wa = 5'd9;
        for (int k = 0; k < 3; k++) tick();
        n_checks++;
        if (sb_err !== 1'b0) begin n_fail++; $display("FAIL cnt9_at3_err: got %b want 0", sb_err); end
        tick();
        iss_valid = 1'b0;
        #1;
        n_checks++;
        if (sb_err !== 1'b1) begin n_fail++; $display("FAIL cnt9_overflow_err: got %b want 1", sb_err); end
        ra1 = 5'd9; use1 = 1'b1; we = 1'b1; wa = 5'd9;
        for (int k = 0; k < 3; k++) begin
            wd = 32'h9000_0000 + k;
            #1;
            n_checks++;
            if (stall !== exp_st[k]) begin n_fail++; $display("FAIL cnt9_drain%0d: got %b want %b", k, stall, exp_st[k]); end
            tick();
        end
        idle();
        ra1 = 5'd9; use1 = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL cnt9_empty: got %b want 0", stall); end
        n_checks++;
        if (sb_err !== 1'b1) begin n_fail++; $display("FAIL sb_err_sticky: got %b want 1", sb_err); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (sb_err !== 1'b0) begin n_fail++; $display("FAIL sb_err_reset: got %b want 0", sb_err); end
    endtask

    task automatic test_issue_plus_write;
        idle();
        iss_valid = 1'b1; iss_wa = 5'd4;
        tick();
        we = 1'b1; wa = 5'd4; wd = 32'hCAFEF00D; ra1 = 5'd4; use1 = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL iw4_stall: got %b want 0", stall); end
        n_checks++;
        if (rd1 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL iw4_bypass: got %h want cafef00d", rd1); end
        tick();
        idle();
        ra1 = 5'd4; use1 = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL iw4_cnt_kept: got %b want 1", stall); end
        n_checks++;
        if (rd1 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL iw4_stored: got %h want cafef00d", rd1); end
        we = 1'b1; wa = 5'd4; wd = 32'h0BADBEEF;
        tick();
        idle();
        ra1 = 5'd4; use1 = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL iw4_drained: got %b want 0", stall); end
    endtask

    task automatic test_reg_zero;
        idle();
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
        iss_valid = 1'b1; iss_wa = 5'd0; use1 = 1'b1; use2 = 1'b1;
        #1;
        n_checks++;
        if (rd1 !== 32'h0) begin n_fail++; $display("FAIL r0_no_bypass: got %h want 0", rd1); end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %b want 0", stall); end
        tick();
        idle();
        use1 = 1'b1;
        #1;
        n_checks++;
        if (rd1 !== 32'h0) begin n_fail++; $display("FAIL r0_stored: got %h want 0", rd1); end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_cnt: got %b want 0", stall); end
        n_checks++;
        if (sb_err !== 1'b0) begin n_fail++; $display("FAIL r0_sb_err: got %b want 0", sb_err); end
    endtask

    task automatic test_back_to_back;
        idle();
        we = 1'b1; wa = 5'd1; wd = 32'h11111111;
        tick();
        wa = 5'd31; wd = 32'hA5A5A5A5;
        tick();
        we = 1'b0; ra1 = 5'd1; ra2 = 5'd31;
        #1;
        n_checks++;
        if (rd1 !== 32'h11111111) begin n_fail++; $display("FAIL b2b_rd1: got %h want 11111111", rd1); end
        n_checks++;
        if (rd2 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL b2b_rd2: got %h want a5a5a5a5", rd2); end
        we = 1'b1; wa = 5'd31; wd = 32'h5A5A0000;
        #1;
        n_checks++;
        if (rd2 !== 32'h5A5A0000) begin n_fail++; $display("FAIL b2b_bypass2: got %h want 5a5a0000", rd2); end
        n_checks++;
        if (rd1 !== 32'h11111111) begin n_fail++; $display("FAIL b2b_rd1_keep: got %h want 11111111", rd1); end
        tick();
        idle();
        ra2 = 5'd31;
        #1;
        n_checks++;
        if (rd2 !== 32'h5A5A0000) begin n_fail++; $display("FAIL b2b_r31: got %h want 5a5a0000", rd2); end
    endtask

    task automatic test_kill_and_reset;
        idle();
        iss_valid = 1'b1; iss_wa = 5'd6;
        tick();
        tick();
        idle();
        kill_valid = 1'b1; kill_wa = 5'd6; we = 1'b1; wa = 5'd6; wd = 32'h66;
        ra1 = 5'd6; use1 = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL kw6_stall: got %b want 1", stall); end
        tick();
        idle();
        ra1 = 5'd6; use1 = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL kw6_cleared: got %b want 0", stall); end
        n_checks++;
        if (sb_err !== 1'b0) begin n_fail++; $display("FAIL kw6_sb_err: got %b want 0", sb_err); end
        idle();
        kill_valid = 1'b1; kill_wa = 5'd7;
        tick();
        idle();
        ra1 = 5'd7; use1 = 1'b1;
        #1;
        n_checks++;
        if (sb_err !== 1'b1) begin n_fail++; $display("FAIL k7_underflow: got %b want 1", sb_err); end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL k7_cnt0: got %b want 0", stall); end
        iss_valid = 1'b1; iss_wa = 5'd11; use1 = 1'b0;
        tick();
        idle();
        ra1 = 5'd11; use1 = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL i11_pending: got %b want 1", stall); end
        reset = 1'b1;
        iss_valid = 1'b1; iss_wa = 5'd12; we = 1'b1; wa = 5'd3; wd = 32'h0000DEAD;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_gate_stall: got %b want 0", stall); end
        tick();
        reset = 1'b0;
        idle();
        ra1 = 5'd11; use1 = 1'b1; ra2 = 5'd12; use2 = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_cnt_clear: got %b want 0", stall); end
        n_checks++;
        if (sb_err !== 1'b0) begin n_fail++; $display("FAIL rst_sb_err: got %b want 0", sb_err); end
        ra1 = 5'd3; ra2 = 5'd1;
        #1;
        n_checks++;
        if (rd1 !== 32'h0) begin n_fail++; $display("FAIL rst_override_wr: got %h want 0", rd1); end
        n_checks++;
        if (rd2 !== 32'h0) begin n_fail++; $display("FAIL rst_regs_clear: got %h want 0", rd2); end
        tick();
    endtask

    initial begin
        test_reset();
        test_bypass_stall();
        test_saturate();
        test_issue_plus_write();
        test_reg_zero();
        test_back_to_back();
        test_kill_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
